rr_path_arbiter: RTL and testbench
==================================

Name: rr_path_arbiter

Overview:
Round-robin arbiter that shares one downstream FIFO-path resource between NREQ requesting paths. It drives the gnt seen by each path's req/gnt handshake. A winner is locked for a bounded burst so back-to-back beats stay contiguous. Grant asserts only against an active request, and every persistent request is served within a fixed bound.

Parameters:
NREQ, 4, number of requesters (>=2)
MAX_BURST, 4, maximum beats per lock before forced rotation (>=1)
IWIDTH, 2, owner index width, $clog2(NREQ)
CWIDTH, 3, burst counter width, $clog2(MAX_BURST+1)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_i  input  NREQ  per-path request (req_o of each path)
ready_i  input  1  downstream can accept a beat this cycle
gnt_o  output  NREQ  one-hot-or-zero grant, combinational
owner_o  output  IWIDTH  locked owner index, registered, valid when busy_o
busy_o  output  1  arbiter in LOCKED state
burst_cnt_o  output  CWIDTH  beats issued in current lock

Behaviour:
- Clock/reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state IDLE, ptr=0, owner_o=0, cnt=0, busy_o=0. gnt_o is forced to 0 while rst_n is low.
- Beat: any cycle with gnt_o != 0.
- Invariants:
  - gnt_o[k] implies req_i[k].
  - $onehot0(gnt_o).
  - gnt_o implies ready_i.
- State IDLE:
  - If ready_i && |req_i: winner W = first set bit of req_i scanning ptr, ptr+1, ... modulo NREQ. gnt_o = onehot(W) in the same cycle (zero-latency, supports same-cycle bypass on req rise). This is beat 1.
  - After that beat: if MAX_BURST==1, ptr <= (W+1) mod NREQ and stay IDLE. Otherwise go to LOCKED with owner_o <= W, cnt <= 1.
  - If !ready_i or req_i==0: gnt_o=0, no state change.
- State LOCKED:
  - gnt_o = onehot(owner) & {NREQ{req_i[owner] && ready_i}}.
  - req_i[owner]==0 (checked regardless of ready_i): gnt_o=0. Next state IDLE, ptr <= owner+1 mod NREQ, cnt <= 0. This costs a one-cycle bubble.
  - Beat with cnt+1==MAX_BURST: next state IDLE, ptr <= owner+1, cnt <= 0. No bubble; the next winner can be granted on the following cycle.
  - Beat otherwise: cnt <= cnt+1.
  - !ready_i with req held: gnt_o=0, cnt and lock held.
  - Other requesters are ignored while LOCKED.
- Pointer rules:
  - ptr only changes on release and always wraps modulo NREQ.
  - For non-power-of-2 NREQ, index NREQ-1 wraps to 0.
- Fairness: with ready_i held high and req_i[k] held high, gnt_o[k] asserts within (NREQ-1)*MAX_BURST cycles.
- burst_cnt_o = cnt. busy_o = (state==LOCKED).
- Reset mid-burst: immediate gnt_o=0. After release of reset: IDLE, ptr=0.
- No overflow paths: cnt never exceeds MAX_BURST-1 in LOCKED.

Test Plan:
1. Reset, req_i=0, ready_i=1 -> gnt_o=0, busy_o=0, owner_o=0, burst_cnt_o=0 for 5 cycles.
2. req_i=4'b0101 held, ready_i=1 from reset -> gnt_o=0001 for 4 cycles, then 0100 for 4 cycles, then 0001. busy_o=1 from the second cycle of each burst.
3. req_i=4'b0100 for one cycle only, ready_i=1 -> gnt_o=0100 that cycle. Next cycle LOCKED with req low, so gnt_o=0. Following cycle busy_o=0 and ptr=3; a later req_i=4'b1001 then grants 1000 first.
4. req_i=4'b0010 held, ready_i toggling 1,0,1,0,... -> gnt_o=0010 only on ready cycles. burst_cnt_o steps 1,1,2,2,3,3. Release after the 4th beat (cycle 7). Bit 1 then wins again on the next ready cycle.
5. req_i=4'b1111 held, ready_i=1 -> owners 0,1,2,3,0 each for exactly 4 beats, no bubbles. No requester waits more than 12 cycles. $onehot(gnt_o) every cycle.
6. rst_n pulsed low mid-burst (owner=2, cnt=2) -> gnt_o=0 asynchronously, busy_o=0. After reset with req_i=4'b0100, grant resumes with ptr=0 scan, so gnt_o=0100.

Source files
------------

// File: rtl/rr_path_arbiter.sv
// rr_path_arbiter
//   Round-robin arbiter sharing one downstream FIFO path between NREQ
//   requesters. The winner is locked for up to MAX_BURST beats so that
//   its back-to-back beats stay contiguous. After the lock ends, the scan
//   pointer rotates past that owner.
//
//   Handshake: a beat is any cycle where gnt_o != 0. gnt_o[k] is raised
//   only when req_i[k] and ready_i are both high in that same cycle, so
//   the requester and the downstream both see the transfer
//   combinationally.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset (also forces gnt_o to 0)
//   req_i        per-path request vector
//   ready_i      downstream accepts a beat this cycle
//   gnt_o        one-hot-or-zero grant, combinational
//   owner_o      locked owner index (meaningful while busy_o)
//   busy_o       arbiter is in LOCKED state (state debug view)
//   burst_cnt_o  beats issued in the current lock
module rr_path_arbiter #(
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4,
    parameter int IWIDTH    = $clog2(NREQ),
    parameter int CWIDTH    = $clog2(MAX_BURST + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_i,
    input  logic              ready_i,
    output logic [NREQ-1:0]   gnt_o,
    output logic [IWIDTH-1:0] owner_o,
    output logic              busy_o,
    output logic [CWIDTH-1:0] burst_cnt_o
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t            state;
    logic [IWIDTH-1:0] ptr;
    logic [IWIDTH-1:0] owner;
    logic [CWIDTH-1:0] cnt;

    logic [IWIDTH-1:0] win;
    logic              any_req;
    logic              owner_req;
    logic              last_beat;
    int                idx;

    // Index after i, wrapping NREQ-1 to 0 (correct for non-power-of-2 NREQ).
    function automatic logic [IWIDTH-1:0] next_idx(input logic [IWIDTH-1:0] i);
        if (int'(i) == NREQ - 1) begin
            return '0;
        end
        return i + IWIDTH'(1);
    endfunction

    // First set request scanning ptr, ptr+1, ... modulo NREQ.
    always_comb begin
        logic found;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req_i[idx]) begin
                win   = IWIDTH'(idx);
                found = 1'b1;
            end
        end
    end

    assign any_req   = |req_i;
    assign owner_req = req_i[owner];
    // The beat that makes cnt reach MAX_BURST ends the lock.
    assign last_beat = (cnt == CWIDTH'(MAX_BURST - 1));

    always_comb begin
        gnt_o = '0;
        if (rst_n) begin
            case (state)
                IDLE: begin
                    if (ready_i && any_req) begin
                        gnt_o[win] = 1'b1;
                    end
                end
                LOCKED: begin
                    if (owner_req && ready_i) begin
                        gnt_o[owner] = 1'b1;
                    end
                end
                default: gnt_o = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            owner <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ready_i && any_req) begin
                        if (MAX_BURST == 1) begin
                            // A single-beat lock never enters LOCKED.
                            ptr <= next_idx(win);
                        end else begin
                            state <= LOCKED;
                            owner <= win;
                            cnt   <= CWIDTH'(1);
                        end
                    end
                end
                LOCKED: begin
                    if (!owner_req) begin
                        // Owner dropped its request: release with a bubble.
                        state <= IDLE;
                        ptr   <= next_idx(owner);
                        cnt   <= '0;
                    end else if (ready_i) begin
                        if (last_beat) begin
                            state <= IDLE;
                            ptr   <= next_idx(owner);
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CWIDTH'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign owner_o     = owner;
    assign busy_o      = (state == LOCKED);
    assign burst_cnt_o = cnt;

endmodule

// File: tb/tb_rr_path_arbiter.sv
module tb_rr_path_arbiter;
    localparam int NREQ      = 4;
    localparam int MAX_BURST = 4;
    localparam int IWIDTH    = 2;
    localparam int CWIDTH    = 3;
    localparam int W         = NREQ + 1 + IWIDTH + CWIDTH;
    localparam int FAIR      = (NREQ - 1) * MAX_BURST;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic              ready = 1'b1;
    logic [NREQ-1:0]   gnt;
    logic [IWIDTH-1:0] owner;
    logic              busy;
    logic [CWIDTH-1:0] cnt;

    logic [W-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    bit fair_on = 1'b0;

    // Reference model: "who holds the path and how many beats so far".
    bit m_locked;
    int m_owner;
    int m_beats;
    int m_ptr;

    rr_path_arbiter #(
        .NREQ(NREQ), .MAX_BURST(MAX_BURST), .IWIDTH(IWIDTH), .CWIDTH(CWIDTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .ready_i(ready),
        .gnt_o(gnt), .owner_o(owner), .busy_o(busy), .burst_cnt_o(cnt)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    function automatic void model_reset();
        m_locked = 1'b0;
        m_owner  = 0;
        m_beats  = 0;
        m_ptr    = 0;
    endfunction

    // Returns expected {gnt, busy, owner, cnt} for this cycle and advances.
    function automatic logic [W-1:0] model_step(input logic [NREQ-1:0] r, input logic rd);
        logic [NREQ-1:0] g;
        logic [W-1:0]    e;
        int              w;
        g = '0;
        e = {g, m_locked, IWIDTH'(m_owner), CWIDTH'(m_beats)};
        if (!m_locked) begin
            if (rd && r != 0) begin
                w = -1;
                for (int i = 0; i < NREQ; i++) begin
                    if (w < 0 && r[(m_ptr + i) % NREQ]) w = (m_ptr + i) % NREQ;
                end
                g[w] = 1'b1;
                if (MAX_BURST == 1) begin
                    m_ptr = (w + 1) % NREQ;
                end else begin
                    m_locked = 1'b1;
                    m_owner  = w;
                    m_beats  = 1;
                end
            end
        end else if (!r[m_owner]) begin
            m_locked = 1'b0;
            m_ptr    = (m_owner + 1) % NREQ;
            m_beats  = 0;
        end else if (rd) begin
            g[m_owner] = 1'b1;
            m_beats++;
            if (m_beats == MAX_BURST) begin
                m_locked = 1'b0;
                m_ptr    = (m_owner + 1) % NREQ;
                m_beats  = 0;
            end
        end
        e[W-1 -: NREQ] = g;
        return e;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [NREQ-1:0] r, input logic rd);
        @(negedge clk);
        rst_n = 1'b1;
        req   = r;
        ready = rd;
        exp_q.push_back(model_step(r, rd));
    endtask

    task automatic reset_cycles(input int n, input logic [NREQ-1:0] r);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst_n = 1'b0;
            req   = r;
            ready = 1'b1;
            model_reset();
            exp_q.push_back('0);
            if (i == 0) begin
                #1;
                total++;
                if (gnt !== '0 || busy !== 1'b0) begin
                    bad++;
                    $display("FAIL async_reset gnt=%b busy=%b required gnt=0000 busy=0", gnt, busy);
                end
            end
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [W-1:0] e;
        int wait_cnt[NREQ];
        for (int k = 0; k < NREQ; k++) wait_cnt[k] = 0;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (gnt !== e[W-1 -: NREQ]) begin
                    bad++;
                    $display("FAIL gnt t=%0t got=%b exp=%b req=%b rdy=%b", $time, gnt, e[W-1 -: NREQ], req, ready);
                end
                total++;
                if (busy !== e[IWIDTH+CWIDTH]) begin
                    bad++;
                    $display("FAIL busy t=%0t got=%b exp=%b", $time, busy, e[IWIDTH+CWIDTH]);
                end
                total++;
                if (owner !== e[CWIDTH +: IWIDTH]) begin
                    bad++;
                    $display("FAIL owner t=%0t got=%0d exp=%0d", $time, owner, e[CWIDTH +: IWIDTH]);
                end
                total++;
                if (cnt !== e[CWIDTH-1:0]) begin
                    bad++;
                    $display("FAIL burst_cnt t=%0t got=%0d exp=%0d", $time, cnt, e[CWIDTH-1:0]);
                end
                total++;
                if ((gnt & ~req) != '0 || !$onehot0(gnt) || (gnt != '0 && !ready)) begin
                    bad++;
                    $display("FAIL invariant t=%0t gnt=%b req=%b rdy=%b required onehot0 subset of req, only when ready", $time, gnt, req, ready);
                end
                if (fair_on) begin
                    for (int k = 0; k < NREQ; k++) begin
                        wait_cnt[k] = (req[k] && !gnt[k]) ? wait_cnt[k] + 1 : 0;
                        total++;
                        if (wait_cnt[k] > FAIR) begin
                            bad++;
                            $display("FAIL fairness req%0d waited=%0d limit=%0d", k, wait_cnt[k], FAIR);
                        end
                    end
                end else begin
                    for (int k = 0; k < NREQ; k++) wait_cnt[k] = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [NREQ-1:0] r;
        model_reset();
        // 1: reset state, then idle with no requests
        reset_cycles(2, '0);
        repeat (5) drive('0, 1'b1);
        // 2: two contending paths, bursts of MAX_BURST
        repeat (20) drive(4'b0101, 1'b1);
        repeat (2) drive('0, 1'b1);
        // 3: single-cycle request, early release, then rotated scan
        drive(4'b0100, 1'b1);
        repeat (2) drive('0, 1'b1);
        repeat (6) drive(4'b1001, 1'b1);
        repeat (2) drive('0, 1'b1);
        // 4: held request with ready toggling
        for (int i = 0; i < 16; i++) drive(4'b0010, (i % 2) == 0);
        repeat (2) drive('0, 1'b1);
        // 5: all requesting, full rotation and fairness bound
        fair_on = 1'b1;
        repeat (40) drive(4'b1111, 1'b1);
        fair_on = 1'b0;
        // 6: reset mid-burst with owner=2, cnt=2
        reset_cycles(1, '0);
        repeat (2) drive(4'b0100, 1'b1);
        reset_cycles(2, 4'b0100);
        repeat (3) drive(4'b0100, 1'b1);
        // random: requests persist for a while, ready mostly high
        r = '0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) r = NREQ'($urandom_range(0, 15));
            if ($urandom_range(0, 299) == 0) begin
                reset_cycles(1, r);
            end else begin
                drive(r, $urandom_range(0, 3) != 0);
            end
        end
        // drain with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
